// File: rtl/md_ctrl.sv
// rtl/md_ctrl.sv - multiply/divide controller owning HI/LO with a fixed-latency busy window
module md_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_start,
    input  logic [2:0]  e_mdop,
    input  logic [31:0] e_rs,
    input  logic [31:0] e_rt,
    input  logic        d_md_use,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [3:0] L_MULT   = 4'(MULT_CYC);
    localparam logic [3:0] L_DIV    = 4'(DIV_CYC);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_is_long;
    logic        w_last;
    logic        w_wr;
    logic [63:0] w_res;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_qm;
    logic [31:0] w_rm;
    logic [31:0] w_quo_s;
    logic [31:0] w_rem_s;
    logic [31:0] w_quo_u;
    logic [31:0] w_rem_u;
    logic        w_b_zero;

    assign w_is_long = (e_mdop == OP_MULT) || (e_mdop == OP_MULTU) ||
                       (e_mdop == OP_DIV)  || (e_mdop == OP_DIVU);
    assign w_last    = (r_state == S_RUN) && (r_cnt <= 4'd1);
    assign md_stall  = d_md_use & (busy | (e_start & w_is_long));
    assign hi        = r_hi;
    assign lo        = r_lo;

    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (e_start && w_is_long) w_next = S_RUN;
            S_RUN:   if (w_last)               w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_RUN);
    end

    // Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000 without relying on simulator overflow behaviour.
    always_comb begin
        w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
        w_prod_u = {32'd0, r_a} * {32'd0, r_b};
        w_b_zero = (r_b == 32'd0);
        w_abs_a  = r_a[31] ? (~r_a + 32'd1) : r_a;
        w_abs_b  = r_b[31] ? (~r_b + 32'd1) : r_b;
        w_qm     = 32'd0;
        w_rm     = 32'd0;
        w_quo_u  = 32'd0;
        w_rem_u  = 32'd0;
        if (!w_b_zero) begin
            w_qm    = w_abs_a / w_abs_b;
            w_rm    = w_abs_a % w_abs_b;
            w_quo_u = r_a / r_b;
            w_rem_u = r_a % r_b;
        end
        w_quo_s = (r_a[31] ^ r_b[31]) ? (~w_qm + 32'd1) : w_qm;
        w_rem_s = r_a[31] ? (~w_rm + 32'd1) : w_rm;
        w_wr    = 1'b1;
        case (r_op)
            OP_MULT:  w_res = w_prod_s;
            OP_MULTU: w_res = w_prod_u;
            OP_DIV:   begin w_res = {w_rem_s, w_quo_s}; w_wr = !w_b_zero; end
            OP_DIVU:  begin w_res = {w_rem_u, w_quo_u}; w_wr = !w_b_zero; end
            default:  begin w_res = {r_hi, r_lo};       w_wr = 1'b0;      end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= 4'd0;
            r_op  <= 3'd0;
            r_a   <= 32'd0;
            r_b   <= 32'd0;
            r_hi  <= 32'd0;
            r_lo  <= 32'd0;
        end else if (r_state == S_IDLE) begin
            if (e_start) begin
                case (e_mdop)
                    OP_MULT, OP_MULTU: begin
                        r_a <= e_rs; r_b <= e_rt; r_op <= e_mdop; r_cnt <= L_MULT;
                    end
                    OP_DIV, OP_DIVU: begin
                        r_a <= e_rs; r_b <= e_rt; r_op <= e_mdop; r_cnt <= L_DIV;
                    end
                    OP_MTHI: r_hi <= e_rs;
                    OP_MTLO: r_lo <= e_rs;
                    default: ;
                endcase
            end
        end else begin
            r_cnt <= r_cnt - 4'd1;
            if (w_last && w_wr) begin
                r_hi <= w_res[63:32];
                r_lo <= w_res[31:0];
            end
        end
    end
endmodule

// File: doc/md_ctrl.md
MD_CTRL -- requirements
Module: md_ctrl

Interface
REQ-001 SHALL provide parameter MULT_CYC, default 5, busy cycles for mult/multu (legal range 1-15).
REQ-002 SHALL provide parameter DIV_CYC, default 10, busy cycles for div/divu (legal range 1-15).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset; sampled on the clk rising edge.
REQ-005 SHALL have port e_start  input  1  E-stage md-class instruction valid this cycle.
REQ-006 SHALL have port e_mdop  input  3  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved.
REQ-007 SHALL have port e_rs  input  32  forwarded rs value (operand A / mthi, mtlo source).
REQ-008 SHALL have port e_rt  input  32  forwarded rt value (operand B).
REQ-009 SHALL have port d_md_use  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
REQ-010 SHALL have port busy  output  1  multi-cycle operation in progress.
REQ-011 SHALL have port md_stall  output  1  stall request to F/D, freeze D and insert E bubble.
REQ-012 SHALL have port hi  output  32  HI register.
REQ-013 SHALL have port lo  output  32  LO register.

Function
REQ-014 SHALL implement two states, IDLE and RUN, plus a 4-bit down-counter cnt and latched opcode/operands.
REQ-015 In IDLE, e_start=1 with mult/multu SHALL latch e_rs, e_rt and opcode, load cnt=MULT_CYC, and enter RUN.
REQ-016 In IDLE, e_start=1 with div/divu SHALL latch e_rs, e_rt and opcode, load cnt=DIV_CYC, and enter RUN.
REQ-017 In IDLE, e_start=1 with mthi SHALL write hi<=e_rs at that edge, with no RUN entry and no busy.
REQ-018 In IDLE, e_start=1 with mtlo SHALL write lo<=e_rs at that edge, with no RUN entry and no busy.
REQ-019 e_start=1 with e_mdop 0 or 7 SHALL cause no state change; e_mdop SHALL be ignored when e_start=0.
REQ-020 In RUN, each edge SHALL decrement cnt; at the edge where cnt==1 the controller SHALL write hi/lo and return to IDLE.
REQ-021 busy SHALL be 1 exactly when the state is RUN, i.e. for MULT_CYC or DIV_CYC cycles after the start edge.
REQ-022 New hi/lo SHALL be visible in the first cycle that busy=0.
REQ-023 mult SHALL write {hi,lo} = signed 64-bit product of the latched operands; multu SHALL write the unsigned product.
REQ-024 div SHALL write lo = signed quotient truncated toward zero and hi = remainder carrying the dividend's sign; divu SHALL write the unsigned quotient and remainder.
REQ-025 Division with divisor 0 SHALL still occupy DIV_CYC cycles and SHALL leave hi/lo unchanged.
REQ-026 Signed div of 0x80000000 by 0xFFFFFFFF SHALL write lo=0x80000000 and hi=0.
REQ-027 e_start=1 while in RUN SHALL be ignored, with no restart, operand relatch or hi/lo write.
REQ-028 md_stall SHALL be combinational: md_stall = d_md_use & (busy | (e_start & e_mdop in {1,2,3,4})).
REQ-029 hi/lo SHALL change only on the edges defined in REQ-017, REQ-018 and REQ-020.

Reset
REQ-030 reset=0 at a rising edge SHALL force state IDLE, cnt=0, hi=0, lo=0 and clear the latched operands, so busy=0 in the next cycle.
REQ-031 reset=0 during RUN SHALL abort the operation with no hi/lo write and reset values as in REQ-030.
REQ-032 reset SHALL take priority over e_start in the same cycle.
REQ-033 While reset=0, md_stall SHALL still follow REQ-028 with busy=0.

Verification
REQ-034 Bench SHALL apply mult e_rs=0xFFFFFFFE (-2), e_rt=3 -> busy=1 for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-035 Bench SHALL apply multu e_rs=0xFFFFFFFF, e_rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 busy cycles.
REQ-036 Bench SHALL apply div e_rs=0xFFFFFFF9 (-7), e_rt=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; then divu by 0 -> 10 busy cycles, hi/lo unchanged.
REQ-037 Bench SHALL drive d_md_use=1 (mflo) during RUN -> md_stall=1 every RUN cycle and in the start cycle, md_stall=0 in the first IDLE cycle.
REQ-038 Bench SHALL apply mthi 0x12345678 then mtlo 0x9ABCDEF0 back-to-back -> hi, lo updated on consecutive edges with busy=0 throughout.
REQ-039 Bench SHALL start div, assert reset=0 on the 4th busy cycle -> next cycle busy=0, hi=lo=0; an e_start during RUN SHALL produce no effect.
